// File: rtl/seg7_capture_decoder.sv
// Captures an active-low 7-segment bus, waits for the pattern to settle, and turns each new
// settled glyph into one hex result on a single-entry valid/ready buffer.
module seg7_capture_decoder #(
  parameter int STABLE_CYCLES = 4,
  parameter int ERRW          = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [6:0]      seg_in,
  input  logic            hex_ready,
  output logic [3:0]      hex_out,
  output logic            hex_err,
  output logic            hex_valid,
  output logic [ERRW-1:0] err_count
);

  localparam int              CNTW    = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNTW-1:0] CNT_MAX = CNTW'(STABLE_CYCLES);
  localparam logic [6:0]      BLANK   = 7'h7F;

  typedef enum logic {TRACK, HOLD} state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [6:0]      r_segQ;
  logic [6:0]      r_cand;
  logic [CNTW-1:0] r_cnt;
  logic [CNTW-1:0] w_cntNext;
  logic [6:0]      r_lastEmit;
  logic [3:0]      r_hexOut;
  logic            r_hexErr;
  logic [ERRW-1:0] r_errCount;
  logic            w_settled;
  logic            w_fresh;
  logic            w_glyphOk;
  logic [3:0]      w_glyphVal;
  logic            w_load;
  logic            w_markBlank;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_segQ <= BLANK;
      r_cand <= BLANK;
      r_cnt  <= '0;
    end else begin
      r_segQ <= seg_in;
      r_cand <= r_segQ;
      r_cnt  <= w_cntNext;
    end
  end

  // Run length including this cycle's sample; settling is judged on this value so the
  // decode happens on the same edge the run reaches STABLE_CYCLES.
  always_comb begin
    w_cntNext = r_cnt;
    if (r_segQ != r_cand) begin
      w_cntNext = CNTW'(1);
    end else if (r_cnt != CNT_MAX) begin
      w_cntNext = r_cnt + CNTW'(1);
    end
  end

  assign w_settled = (w_cntNext == CNT_MAX);
  assign w_fresh   = w_settled && (r_cand != r_lastEmit);

  always_comb begin
    w_glyphOk  = 1'b1;
    w_glyphVal = 4'h0;
    case (r_cand)
      7'h40:   w_glyphVal = 4'h0;
      7'h79:   w_glyphVal = 4'h1;
      7'h24:   w_glyphVal = 4'h2;
      7'h30:   w_glyphVal = 4'h3;
      7'h19:   w_glyphVal = 4'h4;
      7'h12:   w_glyphVal = 4'h5;
      7'h02:   w_glyphVal = 4'h6;
      7'h78:   w_glyphVal = 4'h7;
      7'h00:   w_glyphVal = 4'h8;
      7'h10:   w_glyphVal = 4'h9;
      7'h08:   w_glyphVal = 4'hA;
      7'h03:   w_glyphVal = 4'hB;
      7'h46:   w_glyphVal = 4'hC;
      7'h21:   w_glyphVal = 4'hD;
      7'h06:   w_glyphVal = 4'hE;
      7'h0E:   w_glyphVal = 4'hF;
      default: w_glyphOk  = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= TRACK;
    end else begin
      r_state <= w_stateNext;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      TRACK: if (w_fresh && (r_cand != BLANK)) w_stateNext = HOLD;
      HOLD:  if (hex_ready) w_stateNext = TRACK;
      default: w_stateNext = TRACK;
    endcase
  end

  // A settled blank only re-arms the emit gate; it never produces a result.
  always_comb begin
    hex_valid   = (r_state == HOLD);
    w_load      = (r_state == TRACK) && w_fresh && (r_cand != BLANK);
    w_markBlank = (r_state == TRACK) && w_fresh && (r_cand == BLANK);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lastEmit <= BLANK;
      r_hexOut   <= 4'h0;
      r_hexErr   <= 1'b0;
      r_errCount <= '0;
    end else if (w_load) begin
      r_lastEmit <= r_cand;
      r_hexOut   <= w_glyphOk ? w_glyphVal : 4'h0;
      r_hexErr   <= !w_glyphOk;
      if (!w_glyphOk && (r_errCount != {ERRW{1'b1}})) begin
        r_errCount <= r_errCount + 1'b1;
      end
    end else if (w_markBlank) begin
      r_lastEmit <= BLANK;
    end
  end

  assign hex_out   = r_hexOut;
  assign hex_err   = r_hexErr;
  assign err_count = r_errCount;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: a glyph table, hand-written handshake/reset sequences and
// random stimulus, all checked every cycle against a sample-history reference model.
module tb_seg7_capture_decoder;

  localparam int S    = 4;
  localparam int ERRW = 8;

  logic            clock = 1'b0;
  logic            reset;
  logic [6:0]      seg_in;
  logic            hex_ready;
  logic [3:0]      hex_out;
  logic            hex_err;
  logic            hex_valid;
  logic [ERRW-1:0] err_count;

  seg7_capture_decoder #(.STABLE_CYCLES(S), .ERRW(ERRW)) dut (
    .clock     (clock),
    .reset     (reset),
    .seg_in    (seg_in),
    .hex_ready (hex_ready),
    .hex_out   (hex_out),
    .hex_err   (hex_err),
    .hex_valid (hex_valid),
    .err_count (err_count)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                             7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct {
    logic [6:0] seg;
    logic       emit;
    logic       err;
    logic [3:0] val;
  } vec_t;

  vec_t vecs [21];

  // Reference state: the recent seg_q samples plus what the output buffer should hold.
  logic [6:0]      hist [$];
  logic            mValid;
  logic            mErr;
  logic [3:0]      mOut;
  logic [ERRW-1:0] mErrCount;
  logic [6:0]      mLastEmit;
  logic [4:0]      acceptQ [$];

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic modelEdge();
    bit         settled;
    logic [6:0] pat;
    if (reset) begin
      hist.delete();
      hist.push_back(7'h7F);
      mValid    = 1'b0;
      mOut      = 4'h0;
      mErr      = 1'b0;
      mErrCount = '0;
      mLastEmit = 7'h7F;
      return;
    end
    settled = (hist.size() >= S);
    pat     = hist[hist.size()-1];
    for (int i = 0; i < S && settled; i++) begin
      if (hist[hist.size()-1-i] != pat) settled = 1'b0;
    end
    if (mValid) begin
      if (hex_ready) mValid = 1'b0;
    end else if (settled && pat != mLastEmit) begin
      mLastEmit = pat;
      if (pat != 7'h7F) begin
        mValid = 1'b1;
        mErr   = 1'b1;
        mOut   = 4'h0;
        for (int v = 0; v < 16; v++) begin
          if (glyph[v] == pat) begin
            mErr = 1'b0;
            mOut = 4'(v);
          end
        end
        if (mErr && mErrCount != {ERRW{1'b1}}) mErrCount = mErrCount + 1'b1;
      end
    end
    hist.push_back(seg_in);
    if (hist.size() > S) void'(hist.pop_front());
  endtask

  task automatic checkOutput();
    checkVal("hex_valid", hex_valid, mValid);
    checkVal("hex_out", hex_out, mOut);
    checkVal("hex_err", hex_err, mErr);
    checkVal("err_count", err_count, mErrCount);
  endtask

  // One clock: log a pending handshake, step the model on the edge, compare mid-cycle.
  task automatic tick();
    if (!reset && hex_valid === 1'b1 && hex_ready) acceptQ.push_back({hex_err, hex_out});
    @(posedge clock);
    modelEdge();
    @(negedge clock);
    checkOutput();
  endtask

  task automatic applyStimulus(input logic [6:0] seg, input logic ready, input int n);
    seg_in    = seg;
    hex_ready = ready;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    acceptQ.delete();
  endtask

  task automatic waitValid(input int limit, output int n);
    n = 0;
    while (hex_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int   n;
    int   pulses;
    int   expIdx;
    logic prevValid;
    logic [4:0] expQ [$];

    reset     = 1'b1;
    seg_in    = 7'h7F;
    hex_ready = 1'b0;
    @(negedge clock);
    doReset();
    checkVal("resetValid", hex_valid, 0);
    checkVal("resetOut", hex_out, 0);
    checkVal("resetErr", hex_err, 0);
    checkVal("resetErrCount", err_count, 0);

    // Single glyph: latency from the bus change and exactly one result.
    applyStimulus(7'h7F, 1'b1, 3);
    seg_in = 7'h30;
    waitValid(12, n);
    checkVal("latency", n, 5);
    pulses    = 1;
    prevValid = hex_valid;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (hex_valid && !prevValid) pulses++;
      prevValid = hex_valid;
    end
    checkVal("pulses", pulses, 1);
    checkVal("acceptCount1", acceptQ.size(), 1);
    if (acceptQ.size() >= 1) checkVal("accept1", acceptQ[0], {1'b0, 4'h3});

    // A short glitch between two runs of the same glyph is invisible.
    doReset();
    applyStimulus(7'h40, 1'b1, 8);
    applyStimulus(7'h79, 1'b1, 2);
    applyStimulus(7'h40, 1'b1, 8);
    checkVal("glitchCount", acceptQ.size(), 1);
    if (acceptQ.size() >= 1) checkVal("glitchVal", acceptQ[0], {1'b0, 4'h0});

    // Back-pressure: output stays frozen, the queued glyph follows the accept.
    doReset();
    applyStimulus(7'h0E, 1'b0, 8);
    applyStimulus(7'h21, 1'b0, 8);
    checkVal("holdFrozen", hex_out, 4'hF);
    checkVal("holdValid", hex_valid, 1);
    applyStimulus(7'h21, 1'b1, 4);
    checkVal("bpCount", acceptQ.size(), 2);
    if (acceptQ.size() >= 2) begin
      checkVal("bpFirst", acceptQ[0], {1'b0, 4'hF});
      checkVal("bpSecond", acceptQ[1], {1'b0, 4'hD});
    end

    // Table: every glyph in order, then blanks and illegal patterns.
    for (int g = 0; g < 16; g++) vecs[g] = '{glyph[g], 1'b1, 1'b0, 4'(g)};
    vecs[16] = '{7'h55, 1'b1, 1'b1, 4'h0};
    vecs[17] = '{7'h7F, 1'b0, 1'b0, 4'h0};
    vecs[18] = '{7'h55, 1'b1, 1'b1, 4'h0};
    vecs[19] = '{7'h7F, 1'b0, 1'b0, 4'h0};
    vecs[20] = '{7'h01, 1'b1, 1'b1, 4'h0};
    doReset();
    expQ.delete();
    for (int k = 0; k < 21; k++) begin
      applyStimulus(vecs[k].seg, 1'b1, 6);
      if (vecs[k].emit) expQ.push_back({vecs[k].err, vecs[k].val});
    end
    applyStimulus(7'h01, 1'b1, 3);
    checkVal("tableCount", acceptQ.size(), expQ.size());
    expIdx = 0;
    foreach (expQ[k]) begin
      if (k < acceptQ.size()) begin
        checkVal($sformatf("table[%0d]", k), acceptQ[k], expQ[k]);
        expIdx++;
      end
    end
    checkVal("tableErrCount", err_count, 3);

    // Reset in the middle of a held result, then the same glyph settles afresh.
    doReset();
    applyStimulus(7'h08, 1'b0, 8);
    checkVal("preResetValid", hex_valid, 1);
    reset = 1'b1;
    tick();
    checkVal("resetDropsValid", hex_valid, 0);
    reset = 1'b0;
    waitValid(12, n);
    checkVal("latencyAfterReset", n, 5);
    checkVal("valueAfterReset", hex_out, 4'hA);

    // Random bus activity and back-pressure against the model.
    doReset();
    for (int r = 0; r < 80; r++) begin
      int         pick;
      int         hold;
      logic [6:0] pat;
      pick = $urandom_range(0, 19);
      if (pick < 16) pat = glyph[pick];
      else if (pick == 16) pat = 7'h7F;
      else pat = 7'($urandom_range(0, 127));
      hold   = $urandom_range(1, 7);
      seg_in = pat;
      for (int c = 0; c < hold; c++) begin
        hex_ready = ($urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
